flex_counter_mc: RTL

Multi-channel, parametrised counter block that generalises the existing single-channel flex counter. It adds per-channel up/down direction, synchronous load, wrap or saturate mode, a one-cycle rollover pulse, and optional cascading of channels into a wide prescaler chain. It serves the USB timing and bit-stuff logic, where several independent or chained event counters share one clock domain.

---
 rtl/flex_counter_pkg.sv | 20 ++
 rtl/flex_counter_mc_if.sv | 32 +++
 rtl/flex_counter_ch.sv | 112 +++++++++++
 rtl/flex_counter_mc.sv | 63 ++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared definitions for the multi-channel flex counter.
// Holds the saturate-mode and direction encodings used on the per-channel
// saturate/count_down inputs. It also holds the helper that locates a
// channel's field inside the packed multi-channel buses.
package flex_counter_pkg;

  // saturate input encoding
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // count_down input encoding
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // LSB position of channel ch in a bus packed as ch*width +: width
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/flex_counter_mc_if.sv
// Bus bundle between a multi-channel flex counter and its user.
// The master drives the per-channel controls:
//   clear, load, count_enable, count_down, saturate, load_val, rollover_val.
// The slave (the counter) returns:
//   count_out, rollover_flag, rollover_pulse.
// Vector fields hold one entry per channel. Channel k occupies
// [k*NUM_CNT_BITS +: NUM_CNT_BITS].
interface flex_counter_mc_if #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_CH       = 4
);
  logic [NUM_CH-1:0]              clear;
  logic [NUM_CH-1:0]              load;
  logic [NUM_CH-1:0]              count_enable;
  logic [NUM_CH-1:0]              count_down;
  logic [NUM_CH-1:0]              saturate;
  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]              rollover_flag;
  logic [NUM_CH-1:0]              rollover_pulse;

  modport master (
    output clear, load, count_enable, count_down, saturate, load_val, rollover_val,
    input  count_out, rollover_flag, rollover_pulse
  );

  modport slave (
    input  clear, load, count_enable, count_down, saturate, load_val, rollover_val,
    output count_out, rollover_flag, rollover_pulse
  );
endinterface

// File: rtl/flex_counter_ch.sv
// One flex-counter channel with its count, rollover flag and rollover pulse
// registers.
// Ports:
//   clk, n_rst     : clock and asynchronous active-low reset
//   clear_i        : synchronous clear (highest priority)
//   load_i         : synchronous load of load_val_i
//   en_i           : effective enable (already cascade-gated by the top)
//   down_i, sat_i  : direction and saturate mode
//   load_val_i     : value taken on load
//   rollover_val_i : terminal value R; R = 0 means free-running
//   count_o        : registered count
//   flag_o         : registered "sitting at terminal" level
//   pulse_o        : registered wrap strobe
//   wrap_evt_o     : same-cycle wrap event, feeds the next channel in a cascade
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic                    down_i,
  input  logic                    sat_i,
  input  logic [NUM_CNT_BITS-1:0] load_val_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_o,
  output logic                    flag_o,
  output logic                    pulse_o,
  output logic                    wrap_evt_o
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic [NUM_CNT_BITS-1:0] step_cnt_s;
  logic                    wrap_cond_s;
  logic                    r_zero_s;

  // Counting step: the value one enabled count would produce, and whether it wraps
  always_comb begin
    r_zero_s    = (rollover_val_i == '0);
    wrap_cond_s = 1'b0;
    step_cnt_s  = count_q;
    if (down_i == DIR_UP) begin
      if (r_zero_s) begin
        step_cnt_s = count_q + ONE;
      end else if (count_q >= rollover_val_i) begin
        // in saturate mode an over-range count is forced down to R
        wrap_cond_s = 1'b1;
        step_cnt_s  = (sat_i == MODE_SAT) ? rollover_val_i : ONE;
      end else begin
        step_cnt_s = count_q + ONE;
      end
    end else begin
      if (r_zero_s) begin
        step_cnt_s = count_q - ONE;
      end else if ((count_q <= ONE) || (count_q > rollover_val_i)) begin
        // zero or over-range counts resolve to 1 (saturate) or R (wrap)
        wrap_cond_s = 1'b1;
        step_cnt_s  = (sat_i == MODE_SAT) ? ONE : rollover_val_i;
      end else begin
        step_cnt_s = count_q - ONE;
      end
    end
  end

  // Next state: clear > load > enable > hold; flag tracks the next count
  always_comb begin
    wrap_evt_o = en_i & ~clear_i & ~load_i & ~r_zero_s & (sat_i == MODE_WRAP) & wrap_cond_s;
    pulse_d    = wrap_evt_o;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = step_cnt_s;
    end else begin
      count_d = count_q;
    end
    // re-evaluated every cycle, so a load or a direction change updates it
    if (clear_i || r_zero_s) begin
      flag_d = 1'b0;
    end else if (down_i == DIR_DOWN) begin
      flag_d = (count_d == ONE);
    end else begin
      flag_d = (count_d == rollover_val_i);
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_o = count_q;
  assign flag_o  = flag_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/flex_counter_mc.sv
// Multi-channel flex counter.
// Generates NUM_CH independent channels. With CASCADE = 1, channel k > 0 only
// advances in cycles where channel k-1 wraps, which forms a prescaler chain.
// Ports:
//   clk   : clock
//   n_rst : asynchronous active-low reset
//   bus   : slave side of flex_counter_mc_if (controls in; counts, flags and pulses out)
// Parameters:
//   NUM_CNT_BITS : width of each channel's count
//   NUM_CH       : number of channels
//   CASCADE      : enables the wrap-event chain
module flex_counter_mc
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_CH       = 4,
  parameter bit          CASCADE      = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  flex_counter_mc_if.slave bus
);

  logic [NUM_CH-1:0] wrap_all_s;
  logic              unused_wrap_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic en_s;
    logic wrap_s;

    // Per-channel scalars keep the chain acyclic. It is a ripple through
    // every channel in one cycle.
    if (CASCADE && (k > 0)) begin : g_casc
      assign en_s = bus.count_enable[k] & g_ch[k-1].wrap_s;
    end else begin : g_free
      assign en_s = bus.count_enable[k];
    end

    flex_counter_ch #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_ch (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear_i       (bus.clear[k]),
      .load_i        (bus.load[k]),
      .en_i          (en_s),
      .down_i        (bus.count_down[k]),
      .sat_i         (bus.saturate[k]),
      .load_val_i    (bus.load_val[ch_lsb(k, NUM_CNT_BITS) +: NUM_CNT_BITS]),
      .rollover_val_i(bus.rollover_val[ch_lsb(k, NUM_CNT_BITS) +: NUM_CNT_BITS]),
      .count_o       (bus.count_out[ch_lsb(k, NUM_CNT_BITS) +: NUM_CNT_BITS]),
      .flag_o        (bus.rollover_flag[k]),
      .pulse_o       (bus.rollover_pulse[k]),
      .wrap_evt_o    (wrap_s)
    );

    assign wrap_all_s[k] = wrap_s;
  end

  // The last channel's wrap event (and all of them without cascading) has no consumer
  assign unused_wrap_s = ^wrap_all_s;

endmodule
